// File: rtl/pe_mac.sv
// Systolic-array processing element: fixed-point multiply with a MUL_LAT-deep
// product pipeline, then either pass-sum (mode 0) or local accumulate/drain (mode 1).
module pe_mac #(
  parameter int D_W     = 16,
  parameter int FRAC_W  = 13,
  parameter int MUL_LAT = 2
) (
  input  logic                  I_CLK,
  input  logic                  I_RST,
  input  logic                  I_MODE,
  input  logic                  I_CLR,
  input  logic                  I_W_VLD,
  input  logic signed [D_W-1:0] I_W,
  input  logic                  I_X_VLD,
  input  logic signed [D_W-1:0] I_X,
  input  logic                  I_D_VLD,
  input  logic signed [D_W-1:0] I_D,
  input  logic                  I_DRAIN,
  output logic                  O_X_VLD,
  output logic signed [D_W-1:0] O_X,
  output logic                  O_OUT_VLD,
  output logic signed [D_W-1:0] O_OUT,
  output logic                  O_SAT,
  output logic                  O_ERR
);

  localparam logic [D_W-1:0] MAX_V = {1'b0, {(D_W-1){1'b1}}};
  localparam logic [D_W-1:0] MIN_V = {1'b1, {(D_W-1){1'b0}}};

  // Returns {saturated, value}: round half up, shift out FRAC_W bits, clamp to D_W.
  function automatic logic [D_W:0] round_sat(input logic signed [2*D_W-1:0] p);
    logic signed [2*D_W:0] r;
    r = $signed({p[2*D_W-1], p}) + $signed((2*D_W+1)'(1) << (FRAC_W-1));
    r = r >>> FRAC_W;
    if ((&r[2*D_W:D_W-1]) || !(|r[2*D_W:D_W-1])) return {1'b0, r[D_W-1:0]};
    return {1'b1, r[2*D_W] ? MIN_V : MAX_V};
  endfunction

  function automatic logic [D_W:0] add_sat(input logic signed [D_W-1:0] a,
                                           input logic signed [D_W-1:0] b);
    logic signed [D_W:0] s;
    s = $signed({a[D_W-1], a}) + $signed({b[D_W-1], b});
    if (s[D_W] != s[D_W-1]) return {1'b1, s[D_W] ? MIN_V : MAX_V};
    return {1'b0, s[D_W-1:0]};
  endfunction

  logic signed [D_W-1:0]   weight;
  logic signed [D_W-1:0]   acc;
  logic signed [2*D_W-1:0] prod_p [MUL_LAT];
  logic [MUL_LAT-1:0]      vld_p;

  // Multiply stage p0 then MUL_LAT-1 delay stages; the last stage is product-valid.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      vld_p <= '0;
      for (int i = 0; i < MUL_LAT; i++) prod_p[i] <= '0;
    end else begin
      vld_p[0]  <= I_X_VLD;
      prod_p[0] <= $signed({{D_W{I_X[D_W-1]}}, I_X}) * $signed({{D_W{weight[D_W-1]}}, weight});
      for (int i = 1; i < MUL_LAT; i++) begin
        vld_p[i]  <= vld_p[i-1];
        prod_p[i] <= prod_p[i-1];
      end
    end
  end

  logic                  pv;
  logic [D_W:0]          rnd, sum_d, sum_acc;
  logic signed [D_W-1:0] pr, d_eff;
  logic signed [D_W-1:0] out_n, acc_n;
  logic                  out_vld_n, sat_n, err_n;

  assign pv      = vld_p[MUL_LAT-1];
  assign rnd     = round_sat(prod_p[MUL_LAT-1]);
  assign pr      = rnd[D_W-1:0];
  assign d_eff   = I_D_VLD ? I_D : '0;
  assign sum_d   = add_sat(pr, d_eff);
  assign sum_acc = add_sat(acc, pr);

  // Output stage: mode is sampled here, so in-flight products follow the exit-cycle mode.
  always_comb begin
    out_n     = O_OUT;
    out_vld_n = 1'b0;
    sat_n     = 1'b0;
    acc_n     = acc;
    err_n     = O_ERR;
    if (!I_MODE) begin
      if (pv) begin
        out_n     = sum_d[D_W-1:0];
        out_vld_n = 1'b1;
        sat_n     = rnd[D_W] | sum_d[D_W];
        if (!I_D_VLD) err_n = 1'b1;
      end else if (I_D_VLD) begin
        err_n = 1'b1;
      end
    end else if (I_DRAIN) begin
      if (!I_CLR) begin
        out_n     = pv ? sum_acc[D_W-1:0] : acc;
        out_vld_n = 1'b1;
        sat_n     = pv & (rnd[D_W] | sum_acc[D_W]);
        acc_n     = '0;
      end
      if (I_D_VLD) err_n = 1'b1;
    end else begin
      if (pv && !I_CLR) begin
        acc_n = sum_acc[D_W-1:0];
        sat_n = rnd[D_W] | sum_acc[D_W];
      end
      if (I_D_VLD) begin
        out_n     = I_D;
        out_vld_n = 1'b1;
      end
    end
    if (I_CLR) begin
      acc_n = '0;
      err_n = 1'b0;
    end
  end

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      weight    <= '0;
      acc       <= '0;
      O_X_VLD   <= 1'b0;
      O_X       <= '0;
      O_OUT_VLD <= 1'b0;
      O_OUT     <= '0;
      O_SAT     <= 1'b0;
      O_ERR     <= 1'b0;
    end else begin
      if (I_W_VLD) weight <= I_W;
      O_X_VLD <= I_X_VLD;
      if (I_X_VLD) O_X <= I_X;
      acc       <= acc_n;
      O_OUT_VLD <= out_vld_n;
      O_OUT     <= out_n;
      O_SAT     <= sat_n;
      O_ERR     <= err_n;
    end
  end

endmodule

// File: tb/tb_pe_mac.sv
// Bench for pe_mac: directed fixed-point cases plus a randomized run checked
// every cycle against a transaction-level model (product queue keyed by exit cycle).
module tb_pe_mac;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst, mode, clr, w_vld, x_vld, d_vld, drain;
  logic [15:0] w, x, d;
  logic        o_x_vld, o_out_vld, o_sat, o_err;
  logic [15:0] o_x, o_out;

  int checks = 0;
  int failures = 0;

  pe_mac #(.D_W(16), .FRAC_W(13), .MUL_LAT(LAT)) dut (
    .I_CLK(clk), .I_RST(rst), .I_MODE(mode), .I_CLR(clr),
    .I_W_VLD(w_vld), .I_W(w), .I_X_VLD(x_vld), .I_X(x),
    .I_D_VLD(d_vld), .I_D(d), .I_DRAIN(drain),
    .O_X_VLD(o_x_vld), .O_X(o_x), .O_OUT_VLD(o_out_vld), .O_OUT(o_out),
    .O_SAT(o_sat), .O_ERR(o_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; int val; bit sat; } prod_t;
  prod_t pq[$];
  int cyc = 0;
  int m_w, m_acc, m_out, m_ox;
  bit m_vld, m_sat, m_err, m_oxv;

  function automatic int clamp(input longint v, output bit s);
    s = 1'b0;
    if (v > 32767)  begin s = 1'b1; return 32767;  end
    if (v < -32768) begin s = 1'b1; return -32768; end
    return int'(v);
  endfunction

  // Real-valued x*w/2^13 rounded half up, via floor division.
  function automatic int fx_mul(input int a, input int b, output bit s);
    longint num, q;
    num = longint'(a) * longint'(b) + 64'sd4096;
    q = num / 8192;
    if ((num % 8192) != 0 && num < 0) q = q - 1;
    return clamp(q, s);
  endfunction

  task automatic model_reset();
    pq.delete();
    m_w = 0; m_acc = 0; m_out = 0; m_ox = 0;
    m_vld = 0; m_sat = 0; m_err = 0; m_oxv = 0;
  endtask

  task automatic model_step();
    bit pv, ps, s1, sx;
    int pval, sd, n_out;
    bit n_vld, n_sat;
    pv = 0; ps = 0; s1 = 0; pval = 0;
    sd = int'($signed(d));
    n_out = m_out; n_vld = 0; n_sat = 0;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      pv = 1; pval = pq[0].val; ps = pq[0].sat;
      void'(pq.pop_front());
    end
    if (!mode) begin
      if (pv) begin
        n_out = clamp(longint'(pval) + (d_vld ? sd : 0), s1);
        n_vld = 1; n_sat = ps | s1;
        if (!d_vld) m_err = 1;
      end else if (d_vld) m_err = 1;
    end else if (drain) begin
      if (!clr) begin
        n_out = pv ? clamp(longint'(m_acc) + pval, s1) : m_acc;
        n_vld = 1; n_sat = pv && (ps || s1); m_acc = 0;
      end
      if (d_vld) m_err = 1;
    end else begin
      if (pv && !clr) begin
        m_acc = clamp(longint'(m_acc) + pval, s1);
        n_sat = ps | s1;
      end
      if (d_vld) begin n_out = sd; n_vld = 1; end
    end
    if (clr) begin m_acc = 0; m_err = 0; end
    m_out = n_out; m_vld = n_vld; m_sat = n_sat;
    if (x_vld) begin
      pval = fx_mul(int'($signed(x)), m_w, sx);
      pq.push_back('{cyc + LAT, pval, sx});
      m_ox = int'($signed(x));
    end
    m_oxv = x_vld;
    if (w_vld) m_w = int'($signed(w));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    cyc++;
    #1;
    check_eq("o_out", {16'h0, o_out}, {16'h0, m_out[15:0]});
    check_eq("o_out_vld", {31'h0, o_out_vld}, {31'h0, m_vld});
    check_eq("o_x", {16'h0, o_x}, {16'h0, m_ox[15:0]});
    check_eq("o_x_vld", {31'h0, o_x_vld}, {31'h0, m_oxv});
    check_eq("o_sat", {31'h0, o_sat}, {31'h0, m_sat});
    check_eq("o_err", {31'h0, o_err}, {31'h0, m_err});
  endtask

  task automatic drive(input bit md, input bit wv, input logic [15:0] wd, input bit xv,
                       input logic [15:0] xd, input bit dv, input logic [15:0] dd,
                       input bit dr, input bit cl);
    mode = md; w_vld = wv; w = wd; x_vld = xv; x = xd;
    d_vld = dv; d = dd; drain = dr; clr = cl;
  endtask

  task automatic pass_sum(input string tag, input logic [15:0] wd, input logic [15:0] xd,
                          input logic [15:0] dd, input logic [15:0] exp_out, input bit exp_sat);
    drive(0, 1, wd, 0, 0, 0, 0, 0, 0); cycle();
    drive(0, 0, 0, 1, xd, 0, 0, 0, 0); cycle();
    check_eq({tag, "_ox"}, {16'h0, o_x}, {16'h0, xd});
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    check_eq({tag, "_early_vld"}, {31'h0, o_out_vld}, 32'h0);
    drive(0, 0, 0, 0, 0, 1, dd, 0, 0); cycle();
    check_eq({tag, "_out"}, {16'h0, o_out}, {16'h0, exp_out});
    check_eq({tag, "_vld"}, {31'h0, o_out_vld}, 32'h1);
    check_eq({tag, "_sat"}, {31'h0, o_sat}, {31'h0, exp_sat});
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    bit rmode;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    check_eq("rst_out", {16'h0, o_out}, 32'h0);
    check_eq("rst_vld", {31'h0, o_out_vld}, 32'h0);
    check_eq("rst_err", {31'h0, o_err}, 32'h0);
    cycle(); cycle();
    rst = 1'b0;
    cycle();

    pass_sum("c1", 16'h1000, 16'h2000, 16'h0800, 16'h1800, 1'b0);
    pass_sum("c2a", 16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF, 1'b1);
    pass_sum("c2b", 16'h7FFF, 16'h8000, 16'h0000, 16'h8000, 1'b1);
    pass_sum("c3a", 16'h1000, 16'h0001, 16'h0000, 16'h0001, 1'b0);
    pass_sum("c3b", 16'h1000, 16'hFFFF, 16'h0000, 16'h0000, 1'b0);

    // Accumulate four 0.5 products, drain on the last product-valid cycle.
    drive(1, 1, 16'h1000, 0, 0, 0, 0, 0, 0); cycle();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 1, 16'h2000, 0, 0, 0, 0); cycle();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    check_eq("c4_no_vld", {31'h0, o_out_vld}, 32'h0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0); cycle();
    check_eq("c4_out", {16'h0, o_out}, 32'h4000);
    check_eq("c4_vld", {31'h0, o_out_vld}, 32'h1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    check_eq("c4_once", {31'h0, o_out_vld}, 32'h0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0); cycle();
    check_eq("c4_out2", {16'h0, o_out}, 32'h0);
    check_eq("c4_vld2", {31'h0, o_out_vld}, 32'h1);

    // Protocol errors are sticky until cleared.
    drive(0, 0, 0, 0, 0, 1, 16'h0123, 0, 0); cycle();
    check_eq("c5_err_m0", {31'h0, o_err}, 32'h1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle(); cycle();
    check_eq("c5_sticky", {31'h0, o_err}, 32'h1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); cycle();
    check_eq("c5_clr", {31'h0, o_err}, 32'h0);
    drive(1, 0, 0, 0, 0, 1, 16'h0456, 1, 0); cycle();
    check_eq("c5_err_m1", {31'h0, o_err}, 32'h1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1); cycle();
    check_eq("c5_clr2", {31'h0, o_err}, 32'h0);

    // Reset with a product in flight.
    pass_sum("c6pre", 16'h1000, 16'h2000, 16'h0800, 16'h1800, 1'b0);
    drive(0, 1, 16'h1000, 0, 0, 0, 0, 0, 0); cycle();
    drive(0, 0, 0, 1, 16'h1234, 0, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 1, 16'h0100, 0, 0);
    #2 rst = 1'b1;
    #1;
    check_eq("c6_out", {16'h0, o_out}, 32'h0);
    check_eq("c6_x", {16'h0, o_x}, 32'h0);
    check_eq("c6_xvld", {31'h0, o_x_vld}, 32'h0);
    model_reset();
    cycle();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 1, 16'h0100, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_eq("c6_no_vld", {31'h0, o_out_vld}, 32'h0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); cycle();

    // Randomized traffic; mode held in blocks so accumulation and drains interleave.
    rmode = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) rmode = ~rmode;
      drive(rmode, ($urandom_range(0, 9) == 0), 16'($urandom_range(0, 16'h2FFF)),
            ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h3FFF)),
            ($urandom_range(0, 9) < 3), 16'($urandom),
            ($urandom_range(0, 6) == 0), ($urandom_range(0, 29) == 0));
      if ($urandom_range(0, 19) == 0) w = 16'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
